imem_arbiter: RTL

IMEM_ARBITER -- requirements
Module: imem_arbiter

---
 rtl/imem_arbiter_if.sv | 30 +++
 rtl/imem_arbiter.sv | 112 +++++++++++
 2 files changed

// File: rtl/imem_arbiter_if.sv
// Fetch/debug request-response bundle shared between the two requesters and imem_arbiter.
// master = requester side, slave = arbiter side.
interface imem_arbiter_if #(
  parameter int DATA_WIDTH = 32,
  parameter int BUS_WIDTH  = 17
);
  logic                  f_req;
  logic [BUS_WIDTH-1:0]  f_adr;
  logic                  f_gnt;
  logic                  f_rvalid;
  logic [DATA_WIDTH-1:0] f_rdata;
  logic                  f_err;

  logic                  d_req;
  logic [BUS_WIDTH-1:0]  d_adr;
  logic                  d_gnt;
  logic                  d_rvalid;
  logic [DATA_WIDTH-1:0] d_rdata;
  logic                  d_err;

  modport master (
    output f_req, f_adr, d_req, d_adr,
    input  f_gnt, f_rvalid, f_rdata, f_err, d_gnt, d_rvalid, d_rdata, d_err
  );

  modport slave (
    input  f_req, f_adr, d_req, d_adr,
    output f_gnt, f_rvalid, f_rdata, f_err, d_gnt, d_rvalid, d_rdata, d_err
  );
endinterface

// File: rtl/imem_arbiter.sv
// Two-port (fetch/debug) arbiter in front of a combinational instruction ROM.
// Define IMEM_ARB_RR_EN for round-robin on contention; otherwise fetch has fixed priority.
//   state | meaning
//   IDLE  | accepting a request, grant is combinational
//   READ  | ROM addressed by adr_q, response registered for the owner
module imem_arbiter #(
  parameter int DATA_WIDTH = 32,
  parameter int BUS_WIDTH  = 17
) (
  input  logic                  clk,
  input  logic                  reset,
  imem_arbiter_if.slave         bus,
  output logic [BUS_WIDTH-1:0]  rom_adr,
  input  logic [DATA_WIDTH-1:0] rom_data
);

`ifdef IMEM_ARB_RR_EN
  localparam bit RR_EN = 1'b1;
`else
  localparam bit RR_EN = 1'b0;
`endif

  localparam logic PORT_F = 1'b0;
  localparam logic PORT_D = 1'b1;

  typedef enum logic {IDLE = 1'b0, READ = 1'b1} state_t;

  state_t                state_q, state_d;
  logic [BUS_WIDTH-1:0]  adr_q;
  logic                  owner_q;
  logic                  last_q;
  logic [DATA_WIDTH-1:0] f_rdata_q, d_rdata_q;
  logic                  f_rvalid_q, d_rvalid_q;
  logic                  f_err_q, d_err_q;
  logic                  f_gnt_c, d_gnt_c;
  logic                  misaligned;

  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (f_gnt_c || d_gnt_c) state_d = READ;
      READ:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // With RR_EN clear the contention case degenerates to fetch-always-wins.
  always_comb begin
    f_gnt_c = 1'b0;
    d_gnt_c = 1'b0;
    if (!reset && state_q == IDLE) begin
      if (bus.f_req && bus.d_req) begin
        d_gnt_c = RR_EN && (last_q == PORT_F);
        f_gnt_c = !d_gnt_c;
      end else begin
        f_gnt_c = bus.f_req;
        d_gnt_c = bus.d_req;
      end
    end
  end

  assign misaligned = (adr_q[1:0] != 2'b00);

  always_ff @(posedge clk) begin
    if (reset) begin
      adr_q      <= '0;
      owner_q    <= PORT_D;
      last_q     <= PORT_D;
      f_rdata_q  <= '0;
      d_rdata_q  <= '0;
      f_rvalid_q <= 1'b0;
      d_rvalid_q <= 1'b0;
      f_err_q    <= 1'b0;
      d_err_q    <= 1'b0;
    end else begin
      f_rvalid_q <= 1'b0;
      d_rvalid_q <= 1'b0;
      if (f_gnt_c || d_gnt_c) begin
        adr_q   <= d_gnt_c ? bus.d_adr : bus.f_adr;
        owner_q <= d_gnt_c ? PORT_D : PORT_F;
        last_q  <= d_gnt_c ? PORT_D : PORT_F;
      end
      if (state_q == READ) begin
        if (owner_q == PORT_D) begin
          d_rvalid_q <= 1'b1;
          d_rdata_q  <= misaligned ? '0 : rom_data;
          d_err_q    <= misaligned;
        end else begin
          f_rvalid_q <= 1'b1;
          f_rdata_q  <= misaligned ? '0 : rom_data;
          f_err_q    <= misaligned;
        end
      end
    end
  end

  assign rom_adr      = adr_q;
  assign bus.f_gnt    = f_gnt_c;
  assign bus.d_gnt    = d_gnt_c;
  assign bus.f_rvalid = f_rvalid_q;
  assign bus.d_rvalid = d_rvalid_q;
  assign bus.f_rdata  = f_rdata_q;
  assign bus.d_rdata  = d_rdata_q;
  assign bus.f_err    = f_err_q;
  assign bus.d_err    = d_err_q;

endmodule
